// File: rtl/fpu_pkg.sv
// Shared single-precision field widths, constants and operand classification.
package fpu_pkg;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    // Bit positions inside the 3-bit flags bus {dz, ovf, unf}
    localparam int unsigned DZ  = 2;
    localparam int unsigned OVF = 1;
    localparam int unsigned UNF = 0;

    typedef enum logic [1:0] {
        NORM = 2'd0,
        ZERO = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fclass_e;

    typedef struct packed {
        logic             s;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        fclass_e          cls;
    } fp_unp_t;

    // Split an operand into fields; exponent 0 is flushed to zero (no denormals)
    function automatic fp_unp_t fp_unpack(input logic [31:0] x);
        fp_unp_t u;
        u.s = x[31];
        u.e = x[30:23];
        u.m = x[22:0];
        if (u.e == '0) begin
            u.cls = ZERO;
        end else if (u.e == '1) begin
            u.cls = (u.m == '0) ? INF : NAN;
        end else begin
            u.cls = NORM;
        end
        return u;
    endfunction

endpackage

// File: rtl/finv.sv
// Combinational reciprocal of a normal single-precision value.
// Mantissa is 2^48 / {1,m}, rounded to nearest; special values are not handled.
module finv (
    input  logic [31:0] i_x,
    output logic [31:0] o_y
);

    logic [48:0] w_q;
    logic [24:0] w_qr;

    assign w_q  = (49'd1 << 48) / {25'd0, 1'b1, i_x[22:0]};
    assign w_qr = 25'((w_q + 49'd1) >> 1);

    // w_qr[24] set only when the mantissa is 0, i.e. 1/x is an exact power of two
    always_comb begin
        if (w_qr[24]) begin
            o_y = {i_x[31], 8'd254 - i_x[30:23], 23'd0};
        end else begin
            o_y = {i_x[31], 8'd253 - i_x[30:23], 23'(w_qr[23:0])};
        end
    end

endmodule

// File: rtl/fp_norm_round.sv
// Normalize a [1,4) 48-bit product, round half-up on the guard bit and pack,
// overriding with special-class results and saturating out-of-range exponents.
module fp_norm_round
    import fpu_pkg::*;
(
    input  logic [47:0]       i_p,
    input  logic signed [9:0] i_ez,
    input  logic              i_sign,
    input  fclass_e           i_cls,
    output logic [31:0]       o_y,
    output logic              o_ovf,
    output logic              o_unf
);

    logic [23:0]       w_mr;
    logic signed [9:0] w_ez_n;
    logic signed [9:0] w_ez_r;
    logic              w_unused_low;

    // Bits below the guard position do not take part in rounding
    assign w_unused_low = ^i_p[21:0];

    // Select mantissa window by the product's leading bit, then round
    always_comb begin
        if (i_p[47]) begin
            w_mr   = {1'b0, i_p[46:24]} + {23'd0, i_p[23]};
            w_ez_n = i_ez + 10'sd1;
        end else begin
            w_mr   = {1'b0, i_p[45:23]} + {23'd0, i_p[22]};
            w_ez_n = i_ez;
        end
        // A rounding carry leaves w_mr[22:0] at zero, so only the exponent moves
        w_ez_r = w_mr[23] ? (w_ez_n + 10'sd1) : w_ez_n;
    end

    // Pack result, special classes first, then range saturation
    always_comb begin
        o_y   = '0;
        o_ovf = 1'b0;
        o_unf = 1'b0;
        case (i_cls)
            NAN:  o_y = QNAN;
            INF:  o_y = {i_sign, POS_INF[30:0]};
            ZERO: o_y = {i_sign, 31'd0};
            default: begin
                if (w_ez_r >= 10'sd255) begin
                    o_y   = {i_sign, POS_INF[30:0]};
                    o_ovf = 1'b1;
                end else if (w_ez_r <= 10'sd0) begin
                    o_y   = {i_sign, 31'd0};
                    o_unf = 1'b1;
                end else begin
                    o_y = {i_sign, w_ez_r[7:0], w_mr[22:0]};
                end
            end
        endcase
    end

endmodule

// File: rtl/fdiv_pipe.sv
// Pipelined single-precision divider y = a * (1/b) with valid/ready flow control.
// Stage 1: classify, reciprocal; stage 2: split multiply + exponent;
// stage 3: sum partials; output register holds the normalized, rounded result.
module fdiv_pipe #(
    parameter int EXC_EN = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic [2:0]  flags
);
    import fpu_pkg::*;

    logic              w_advance;
    fp_unp_t           w_ua;
    fp_unp_t           w_ub;
    logic [31:0]       w_rinv;
    logic              w_unused_rsign;
    fclass_e           w_cls;
    logic              w_dz;
    logic [23:0]       w_mant_a;
    logic [23:0]       w_mant_r;
    logic [31:0]       w_y;
    logic              w_ovf;
    logic              w_unf;
    logic [2:0]        w_flags;

    logic              r_v1, r_v2, r_v3;
    logic              r_s1_sign, r_s2_sign, r_s3_sign;
    fclass_e           r_s1_cls, r_s2_cls, r_s3_cls;
    logic              r_s1_dz, r_s2_dz, r_s3_dz;
    logic [22:0]       r_s1_ma, r_s1_rm;
    logic [7:0]        r_s1_ea, r_s1_eb, r_s1_er;
    logic [35:0]       r_s2_pp_hi, r_s2_pp_lo;
    logic signed [9:0] r_s2_ez, r_s3_ez;
    logic [47:0]       r_s3_p;
    logic              r_out_valid;
    logic [31:0]       r_y;
    logic [2:0]        r_flags;

    assign w_advance = !r_out_valid | out_ready;
    assign in_ready  = w_advance & rstn;
    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign flags     = r_flags;

    assign w_ua = fp_unpack(a);
    assign w_ub = fp_unpack(b);

    // Reciprocal of b scaled into [1,2); its exponent field is then 126 or 127
    finv u_finv (
        .i_x ({1'b0, 8'd127, w_ub.m}),
        .o_y (w_rinv)
    );
    assign w_unused_rsign = w_rinv[31];

    // Special-case class in priority order
    always_comb begin
        w_cls = NORM;
        w_dz  = 1'b0;
        if (EXC_EN != 0) begin
            if (w_ua.cls == NAN || w_ub.cls == NAN ||
                (w_ua.cls == ZERO && w_ub.cls == ZERO) ||
                (w_ua.cls == INF  && w_ub.cls == INF)) begin
                w_cls = NAN;
            end else if (w_ub.cls == ZERO) begin
                w_cls = INF;
                w_dz  = 1'b1;
            end else if (w_ua.cls == INF) begin
                w_cls = INF;
            end else if (w_ub.cls == INF) begin
                w_cls = ZERO;
            end else if (w_ua.cls == ZERO) begin
                w_cls = ZERO;
            end
        end
    end

    // Stage 1 register: operand fields and reciprocal
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_v1      <= 1'b0;
            r_s1_sign <= 1'b0;
            r_s1_cls  <= NORM;
            r_s1_dz   <= 1'b0;
            r_s1_ma   <= '0;
            r_s1_ea   <= '0;
            r_s1_eb   <= '0;
            r_s1_rm   <= '0;
            r_s1_er   <= '0;
        end else if (w_advance) begin
            r_v1      <= in_valid;
            r_s1_sign <= w_ua.s ^ w_ub.s;
            r_s1_cls  <= w_cls;
            r_s1_dz   <= w_dz;
            r_s1_ma   <= w_ua.m;
            r_s1_ea   <= w_ua.e;
            r_s1_eb   <= w_ub.e;
            r_s1_rm   <= w_rinv[22:0];
            r_s1_er   <= w_rinv[30:23];
        end
    end

    assign w_mant_a = {1'b1, r_s1_ma};
    assign w_mant_r = {1'b1, r_s1_rm};

    // Stage 2 register: the 24x24 product is split into two 24x12 partials
    // so the multiplier spans two register stages
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_v2       <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_cls   <= NORM;
            r_s2_dz    <= 1'b0;
            r_s2_pp_hi <= '0;
            r_s2_pp_lo <= '0;
            r_s2_ez    <= '0;
        end else if (w_advance) begin
            r_v2       <= r_v1;
            r_s2_sign  <= r_s1_sign;
            r_s2_cls   <= r_s1_cls;
            r_s2_dz    <= r_s1_dz;
            r_s2_pp_hi <= 36'(w_mant_a) * 36'(w_mant_r[23:12]);
            r_s2_pp_lo <= 36'(w_mant_a) * 36'(w_mant_r[11:0]);
            r_s2_ez    <= $signed({2'b00, r_s1_ea}) + $signed({2'b00, r_s1_er})
                        - $signed({2'b00, r_s1_eb});
        end
    end

    // Stage 3 register: full 48-bit product
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_v3      <= 1'b0;
            r_s3_sign <= 1'b0;
            r_s3_cls  <= NORM;
            r_s3_dz   <= 1'b0;
            r_s3_p    <= '0;
            r_s3_ez   <= '0;
        end else if (w_advance) begin
            r_v3      <= r_v2;
            r_s3_sign <= r_s2_sign;
            r_s3_cls  <= r_s2_cls;
            r_s3_dz   <= r_s2_dz;
            r_s3_p    <= {r_s2_pp_hi, 12'd0} + {12'd0, r_s2_pp_lo};
            r_s3_ez   <= r_s2_ez;
        end
    end

    fp_norm_round u_norm (
        .i_p    (r_s3_p),
        .i_ez   (r_s3_ez),
        .i_sign (r_s3_sign),
        .i_cls  (r_s3_cls),
        .o_y    (w_y),
        .o_ovf  (w_ovf),
        .o_unf  (w_unf)
    );

    // Assemble flag bus from the carried dz and the range outcome
    always_comb begin
        w_flags      = '0;
        w_flags[DZ]  = r_s3_dz;
        w_flags[OVF] = w_ovf;
        w_flags[UNF] = w_unf;
    end

    // Output register: held while the consumer stalls
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_flags     <= '0;
        end else if (w_advance) begin
            r_out_valid <= r_v3;
            r_y         <= w_y;
            r_flags     <= (EXC_EN != 0) ? w_flags : 3'b000;
        end
    end

endmodule

// File: tb/tb_fdiv_pipe.sv
// Scoreboard bench for fdiv_pipe: driver pushes expected results from a
// real-valued reference model, monitor pops and compares on each transfer.
module tb_fdiv_pipe;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] y;
    logic [2:0]  flags;

    typedef struct {
        logic [31:0] a_in;
        logic [31:0] b_in;
        logic [31:0] y;
        logic [2:0]  fl;
        int          tol;
        int          acc;
        bit          chk_lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;
    bit   bp     = 1'b0;

    fdiv_pipe #(.EXC_EN(1)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .flags     (flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic real pow2(input int k);
        real r;
        r = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
        else        for (int i = 0; i < -k; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real mag(input logic [31:0] x);
        return (1.0 + real'(x[22:0]) / 8388608.0) * pow2(int'(x[30:23]) - 127);
    endfunction

    // Reference: classify, divide in real arithmetic, round to nearest single
    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv);
        exp_t r;
        bit   s, az, bz, ai, bi, an, bn;
        real  q;
        int   e, m;
        s  = av[31] ^ bv[31];
        az = (av[30:23] == 8'h00);
        bz = (bv[30:23] == 8'h00);
        ai = (av[30:23] == 8'hFF) && (av[22:0] == 23'd0);
        bi = (bv[30:23] == 8'hFF) && (bv[22:0] == 23'd0);
        an = (av[30:23] == 8'hFF) && (av[22:0] != 23'd0);
        bn = (bv[30:23] == 8'hFF) && (bv[22:0] != 23'd0);
        r.a_in = av; r.b_in = bv; r.fl = 3'b000; r.tol = 0; r.acc = 0; r.chk_lat = 1'b0;
        if (an || bn || (az && bz) || (ai && bi)) r.y = 32'h7FC00000;
        else if (bz) begin r.y = {s, 8'hFF, 23'd0}; r.fl = 3'b100; end
        else if (ai) r.y = {s, 8'hFF, 23'd0};
        else if (bi) r.y = {s, 31'd0};
        else if (az) r.y = {s, 31'd0};
        else begin
            q = mag(av) / mag(bv);
            e = 0;
            while (q >= 2.0) begin q = q / 2.0; e++; end
            while (q < 1.0)  begin q = q * 2.0; e--; end
            m = $rtoi(q * 8388608.0 + 0.5);
            if (m >= 16777216) begin m = 8388608; e++; end
            e = e + 127;
            if (e >= 255)    begin r.y = {s, 8'hFF, 23'd0}; r.fl = 3'b010; end
            else if (e <= 0) begin r.y = {s, 31'd0};        r.fl = 3'b001; end
            else begin r.y = {s, 8'(e), 23'(m)}; r.tol = 2; end
        end
        return r;
    endfunction

    function automatic logic [31:0] rnd_norm();
        logic [31:0] v;
        v = {1'($urandom_range(0, 1)), 8'($urandom_range(80, 175)), 23'($urandom)};
        return v;
    endfunction

    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input int tol_ovr);
        exp_t e;
        int   tries;
        e = model(av, bv);
        if (tol_ovr >= 0 && e.tol > 0) e.tol = tol_ovr;
        tries = 0;
        forever begin
            @(negedge clk);
            in_valid = 1'b1; a = av; b = bv;
            #1;
            if (in_ready) begin
                e.acc = cycle + 1;
                e.chk_lat = !bp;
                sb.push_back(e);
                break;
            end
            tries++;
            if (tries > 1000) begin
                checks++; errors++;
                $display("FAIL issue_timeout a=%h b=%h in_ready stuck at %b, required 1", av, bv, in_ready);
                break;
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 5000) begin @(negedge clk); n++; end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d, required 0", sb.size());
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // Randomized consumer backpressure when enabled
    initial forever begin
        @(negedge clk);
        out_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Monitor: ready rule, stall holding, scoreboard compare on each transfer
    initial begin : monitor
        logic [31:0] hold_y;
        logic [2:0]  hold_f;
        bit          stalled;
        exp_t        e;
        int          d;
        bit          ok;
        stalled = 1'b0; hold_y = '0; hold_f = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rstn) begin stalled = 1'b0; continue; end
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++;
                $display("FAIL in_ready got=%b want=%b", in_ready, !(out_valid && !out_ready));
            end
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || y !== hold_y || flags !== hold_f) begin
                    errors++;
                    $display("FAIL stall_hold got v=%b y=%h f=%b want v=1 y=%h f=%b",
                             out_valid, y, flags, hold_y, hold_f);
                end
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output y=%h flags=%b, required no output", y, flags);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (e.tol == 0) ok = (y === e.y);
                    else begin
                        d = int'(y[30:0]) - int'(e.y[30:0]);
                        if (d < 0) d = -d;
                        ok = (y[31] === e.y[31]) && (y[30:23] != 8'hFF) &&
                             (y[30:23] != 8'h00) && (d <= e.tol);
                    end
                    if (!ok) begin
                        errors++;
                        $display("FAIL y a=%h b=%h got=%h want=%h tol=%0d", e.a_in, e.b_in, y, e.y, e.tol);
                    end
                    checks++;
                    if (flags !== e.fl) begin
                        errors++;
                        $display("FAIL flags a=%h b=%h got=%b want=%b", e.a_in, e.b_in, flags, e.fl);
                    end
                    if (e.chk_lat) begin
                        checks++;
                        if (cycle != e.acc + 3) begin
                            errors++;
                            $display("FAIL latency a=%h b=%h got=%0d want=%0d", e.a_in, e.b_in,
                                     cycle - e.acc, 3);
                        end
                    end
                end
            end
            stalled = out_valid && !out_ready;
            hold_y  = y;
            hold_f  = flags;
        end
    end

    initial begin
        #(5_000_000);
        $display("FAIL watchdog simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] da [13];
        logic [31:0] dbv[13];
        int          dt [13];
        da  = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h00000000,
                32'h7F800000, 32'h40000000, 32'h3F800000, 32'h7F000000, 32'h00800000,
                32'h7F7FFFFF, 32'h7FC00001, 32'hFF800000};
        dbv = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000, 32'h00000000,
                32'h40000000, 32'h7F800000, 32'h00000001, 32'h00800000, 32'h7F000000,
                32'h7F7FFFFF, 32'h3F800000, 32'h7F800000};
        dt  = '{1, 1, -1, -1, -1, -1, -1, -1, -1, -1, 1, -1, -1};

        #1 rstn = 1'b0;
        #2;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_y", y, 32'd0);
        chk("reset_flags", {29'd0, flags}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Directed values, no backpressure
        bp = 1'b0;
        for (int i = 0; i < 13; i++) issue(da[i], dbv[i], dt[i]);
        idle();
        drain();

        // Back-to-back stream with random backpressure
        bp = 1'b1;
        for (int i = 0; i < 20; i++) issue(rnd_norm(), rnd_norm(), -1);
        idle();
        drain();

        // Reset with one result at the output and three in flight
        bp = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) issue(rnd_norm(), rnd_norm(), -1);
        @(posedge clk);
        #2;
        chk("pre_reset_out_valid", {31'd0, out_valid}, 32'd1);
        rstn = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset_y", y, 32'd0);
        chk("midreset_flags", {29'd0, flags}, 32'd0);
        chk("midreset_in_ready", {31'd0, in_ready}, 32'd0);
        sb.delete();
        @(posedge clk);
        #2 rstn = 1'b1;
        issue(32'h40C00000, 32'h40000000, 1);
        idle();
        drain();
        repeat (6) @(negedge clk);

        // Random normal pairs, half under backpressure
        bp = 1'b1;
        for (int i = 0; i < 5000; i++) issue(rnd_norm(), rnd_norm(), -1);
        idle();
        drain();
        bp = 1'b0;
        for (int i = 0; i < 5000; i++) issue(rnd_norm(), rnd_norm(), -1);
        idle();
        drain();
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
